gecko_mem_arbiter: RTL
======================

# gecko_mem_arbiter

Shares the single data-memory port between two requesters: requester 0 is the gecko execute stage's load/store request stream, and requester 1 is a secondary master such as a debug or DMA engine. The block arbitrates round-robin and registers the winning request onto the memory port. It records the owner of every outstanding read in an in-order tag FIFO, so each read response is steered back to the requester that issued it. It sits between the execute stage and the data memory.

## Interface
Parameters:
- ADDR_WIDTH, 32, memory address width.
- DATA_WIDTH, 32, memory data width; write_enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, maximum reads in flight; must be a power of 2 and at least 2.

Ports:
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, synchronous reset, active-low.
- req0, std_mem_intf.in, —, execute-stage requests: valid/ready, read_enable, write_enable, addr, data.
- req1, std_mem_intf.in, —, secondary-master requests, same fields as req0.
- mem_request, std_mem_intf.out, —, registered request to memory.
- mem_result, std_mem_intf.in, —, memory read data; valid/ready and data fields only.
- resp0, std_mem_intf.out, —, read data returned to requester 0.
- resp1, std_mem_intf.out, —, read data returned to requester 1.

## Operation
- A request is a read if read_enable=1 and a write otherwise. Only reads produce a memory response; writes are fire-and-forget.
- Output slot: a single register stage holds mem_request.valid and its payload. The slot can accept a new request when it is empty, or when mem_request.valid && mem_request.ready in the same cycle.
- Eligibility: requester k is eligible when req_k.valid=1. If its request is a read, it is additionally eligible only when the tag FIFO count < MAX_OUTSTANDING.
- Round-robin arbitration:
  - last_grant is a 1-bit register. The requester that is not last_grant wins when both are eligible.
  - After reset, last_grant=1, so requester 0 has priority first.
  - A single eligible requester always wins.
  - last_grant updates only on an actual grant.
- Grant: req_k.ready=1 only for the winner, and only when the slot can accept. On the req_k handshake:
  - The payload is loaded into mem_request.
  - If the request is a read, tag k is pushed into the FIFO.
- The tag FIFO holds MAX_OUTSTANDING entries of 1 bit each, with a count register of width log2(MAX_OUTSTANDING)+1.
  - A push is permitted only when count < MAX_OUTSTANDING. A pop in the same cycle does not free space for that cycle's push.
  - A simultaneous push and pop leaves count unchanged.
- Response steering is combinational:
  - resp_k.valid = mem_result.valid && !empty && head==k.
  - resp_k.data = mem_result.data.
  - mem_result.ready = ready of the selected resp_k, or 0 when the FIFO is empty.
  - The FIFO pops on the mem_result handshake.
- A mem_result.valid arriving while the FIFO is empty is a protocol error. It is stalled (ready=0) and flagged by a simulation assertion.

## Timing
- Reset (rst=0 at a clock edge):
  - mem_request.valid=0.
  - FIFO count=0, with read/write pointers=0.
  - last_grant=1.
  - Payload registers are don't-care.
  - resp0.valid, resp1.valid and mem_result.ready evaluate to 0 while the FIFO is empty.
- Reset asserted mid-transaction discards all queued tags. Responses that arrive after reset are treated as protocol errors.
- Request latency: a req_k handshake in cycle N gives mem_request.valid=1 in cycle N+1.
- Throughput: one grant per cycle when memory holds mem_request.ready=1.
- Response latency: 0 cycles (combinational mem_result → resp_k).
- A mem_request.valid=1 output holds its payload stable until mem_request.ready=1.
- With a full FIFO, reads from both requesters stall while writes continue to be granted.

## Structure
- Shared gecko package:
  - gecko_mem_requester_t, a 1-bit enum GECKO_MEM_REQ_EXECUTE / GECKO_MEM_REQ_AUX.
  - A default GECKO_MEM_MAX_OUTSTANDING constant.
- Natural sub-module: a std_fifo instance of width 1 and depth MAX_OUTSTANDING used as the tag FIFO. It exposes count/full/empty, and its push is gated externally with the count rule above.
- The arbiter, output register and steering logic live in gecko_mem_arbiter itself.

## Test plan
- Reset, then only req0 issues a read of 0x100 → mem_request.valid the next cycle with addr=0x100 and tag 0 queued. A response of 0xDEADBEEF appears on resp0 only; resp1.valid stays 0.
- Both requesters hold valid reads continuously with memory always ready → grants alternate 0,1,0,1, and responses return in order to the matching port.
- Issue MAX_OUTSTANDING=4 reads with no response, then a 5th read and a write → the read is stalled (ready=0) and the write is granted. One response frees the read, which is granted the next cycle.
- mem_request.ready held 0 for 3 cycles with both requesters valid → payload stable, no further grants, req0.ready=req1.ready=0.
- resp1.ready=0 while its response is at the FIFO head → mem_result.ready=0, and the FIFO is not popped until resp1.ready rises.
- rst=0 with 2 reads outstanding → count=0, mem_request.valid=0, last_grant=1. The first post-reset contested grant goes to requester 0.

Source files
------------

// File: rtl/gecko_mem_arbiter_pkg.sv
// Shared gecko memory-arbiter types: requester identity and default read depth.
package gecko_mem_arbiter_pkg;
  typedef enum logic {
    GECKO_MEM_REQ_EXECUTE = 1'b0,
    GECKO_MEM_REQ_AUX     = 1'b1
  } gecko_mem_requester_t;

  localparam int GECKO_MEM_MAX_OUTSTANDING = 4;
endpackage

// File: rtl/std_mem_intf.sv
// Valid/ready memory request/response bundle; "in" is the consumer view, "out" the producer view.
interface std_mem_intf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic                    read_enable;
  logic [DATA_WIDTH/8-1:0] write_enable;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   data;

  modport in  (input valid, read_enable, write_enable, addr, data, output ready);
  modport out (output valid, read_enable, write_enable, addr, data, input ready);
endinterface

// File: rtl/std_fifo.sv
// Small synchronous FIFO with occupancy count; DEPTH must be a power of 2 so pointers wrap naturally.
module std_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/gecko_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between execute and an aux master,
// with an in-order owner-tag FIFO that steers each read response back to its issuer.
module gecko_mem_arbiter
  import gecko_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = GECKO_MEM_MAX_OUTSTANDING
) (
  input  logic     clk,
  input  logic     rst,
  std_mem_intf.in  req0,
  std_mem_intf.in  req1,
  std_mem_intf.out mem_request,
  std_mem_intf.in  mem_result,
  std_mem_intf.out resp0,
  std_mem_intf.out resp1
);
  localparam int CW  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int WEW = DATA_WIDTH / 8;

  typedef struct packed {
    logic                  re;
    logic [WEW-1:0]        we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } mem_req_t;

  mem_req_t             pl0, pl1, win_pl, slot_pl;
  logic                 slot_vld, slot_open, grant, has_space;
  logic [1:0]           elig;
  gecko_mem_requester_t winner, last_grant, head;
  logic [CW-1:0]        tag_count;
  logic                 tag_full, tag_empty, tag_head, tag_push, tag_pop;

  assign pl0 = '{re: req0.read_enable, we: req0.write_enable, addr: req0.addr, data: req0.data};
  assign pl1 = '{re: req1.read_enable, we: req1.write_enable, addr: req1.addr, data: req1.data};

  // Reads need a free tag slot; writes never do.
  assign has_space = (tag_count < CW'(MAX_OUTSTANDING));
  assign elig[0]   = req0.valid && (!req0.read_enable || has_space);
  assign elig[1]   = req1.valid && (!req1.read_enable || has_space);

  always_comb begin
    winner = GECKO_MEM_REQ_EXECUTE;
    if (elig == 2'b11)
      winner = (last_grant == GECKO_MEM_REQ_AUX) ? GECKO_MEM_REQ_EXECUTE : GECKO_MEM_REQ_AUX;
    else if (elig[1])
      winner = GECKO_MEM_REQ_AUX;
  end

  assign slot_open  = !slot_vld || mem_request.ready;
  assign grant      = slot_open && (|elig);
  assign req0.ready = grant && (winner == GECKO_MEM_REQ_EXECUTE);
  assign req1.ready = grant && (winner == GECKO_MEM_REQ_AUX);
  assign win_pl     = (winner == GECKO_MEM_REQ_AUX) ? pl1 : pl0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_vld   <= 1'b0;
      last_grant <= GECKO_MEM_REQ_AUX;
    end else if (grant) begin
      slot_vld   <= 1'b1;
      last_grant <= winner;
    end else if (mem_request.ready) begin
      slot_vld   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) slot_pl <= win_pl;
  end

  assign mem_request.valid        = slot_vld;
  assign mem_request.read_enable  = slot_pl.re;
  assign mem_request.write_enable = slot_pl.we;
  assign mem_request.addr         = slot_pl.addr;
  assign mem_request.data         = slot_pl.data;

  assign tag_push = grant && win_pl.re;
  assign tag_pop  = mem_result.valid && mem_result.ready;

  std_fifo #(.WIDTH(1), .DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_push),
    .push_data (winner),
    .pop       (tag_pop),
    .pop_data  (tag_head),
    .count     (tag_count),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  assign head = gecko_mem_requester_t'(tag_head);

  assign resp0.valid        = mem_result.valid && !tag_empty && (head == GECKO_MEM_REQ_EXECUTE);
  assign resp1.valid        = mem_result.valid && !tag_empty && (head == GECKO_MEM_REQ_AUX);
  assign resp0.data         = mem_result.data;
  assign resp1.data         = mem_result.data;
  assign resp0.read_enable  = 1'b1;
  assign resp1.read_enable  = 1'b1;
  assign resp0.write_enable = '0;
  assign resp1.write_enable = '0;
  assign resp0.addr         = '0;
  assign resp1.addr         = '0;
  assign mem_result.ready   = !tag_empty &&
                              ((head == GECKO_MEM_REQ_AUX) ? resp1.ready : resp0.ready);

  logic unused_sig;
  assign unused_sig = ^{mem_result.read_enable, mem_result.write_enable, mem_result.addr, tag_full};

  // A response with no outstanding read has no owner to go to.
  mem_result_has_owner: assert property (@(posedge clk) disable iff (!rst)
    !(mem_result.valid && tag_empty));
endmodule
